// File: rtl/packet_mem_writer.sv
// packet_mem_writer: fill side of the shared packet buffer.
// Packs a byte stream little-endian into 32-bit words, writes DEPTH_WORDS words
// to the packet BRAM, pulses done_writing, then waits for the reader to take
// (out_of_data=0) and drain (out_of_data=1) the buffer before refilling.
// Optional feature macro: CHECKSUM_EN (trailing XOR byte checked per block).
module packet_mem_writer #(
    parameter int unsigned DEPTH_WORDS = 48,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              out_of_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              done_writing,
    output logic              busy,
    output logic              checksum_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {
        S_FILL,
        S_CKSUM,
        S_DONE,
        S_WAIT_TAKE,
        S_WAIT_DRAIN
    } state_t;
`else
    typedef enum logic [2:0] {
        S_FILL,
        S_DONE,
        S_WAIT_TAKE,
        S_WAIT_DRAIN
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [1:0]          lane_q, lane_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic [31:0]         word_q, word_d;
    logic                byte_ready_q, byte_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
`ifdef CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
    logic                cksum_err_q, cksum_err_d;
`endif

    // State and output registers; all outputs come straight from flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_FILL;
            lane_q       <= 2'd0;
            word_idx_q   <= '0;
            word_q       <= 32'd0;
            byte_ready_q <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CHECKSUM_EN
            xor_q        <= 8'd0;
            cksum_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            word_idx_q   <= word_idx_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
`ifdef CHECKSUM_EN
            xor_q        <= xor_d;
            cksum_err_q  <= cksum_err_d;
`endif
        end
    end

    // Next-state and next-output logic. byte_ready_q low inside FILL marks the
    // cycle in which the final word of the block is being written.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        word_idx_d   = word_idx_q;
        word_d       = word_q;
        byte_ready_d = byte_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = 1'b0;
        busy_d       = 1'b0;
`ifdef CHECKSUM_EN
        xor_d        = xor_q;
        cksum_err_d  = 1'b0;
`endif

        unique case (state_q)
            S_FILL: begin
                if (!byte_ready_q) begin
`ifdef CHECKSUM_EN
                    state_d      = S_CKSUM;
                    byte_ready_d = 1'b1;
`else
                    state_d      = S_DONE;
                    done_d       = 1'b1;
`endif
                end else if (byte_valid) begin
                    word_d[{lane_q, 3'b000} +: 8] = byte_data;
                    lane_d = lane_q + 2'd1;
`ifdef CHECKSUM_EN
                    xor_d  = xor_q ^ byte_data;
`endif
                    if (lane_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {byte_data, word_q[23:0]};
                        mem_addr_d  = ADDR_W'({word_idx_q, 2'b00});
                        if (word_idx_q == LAST_IDX) begin
                            byte_ready_d = 1'b0;
                        end else begin
                            word_idx_d = word_idx_q + IDX_W'(1);
                        end
                    end
                end
            end

`ifdef CHECKSUM_EN
            S_CKSUM: begin
                if (byte_valid && byte_ready_q) begin
                    if (byte_data == xor_q) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        byte_ready_d = 1'b0;
                    end else begin
                        state_d      = S_FILL;
                        cksum_err_d  = 1'b1;
                        word_idx_d   = '0;
                        lane_d       = 2'd0;
                        xor_d        = 8'd0;
                        byte_ready_d = 1'b1;
                    end
                end
            end
`endif

            S_DONE: begin
                state_d      = S_WAIT_TAKE;
                busy_d       = 1'b1;
                byte_ready_d = 1'b0;
            end

            S_WAIT_TAKE: begin
                busy_d = 1'b1;
                if (!out_of_data) begin
                    state_d = S_WAIT_DRAIN;
                end
            end

            S_WAIT_DRAIN: begin
                if (out_of_data) begin
                    state_d      = S_FILL;
                    word_idx_d   = '0;
                    lane_d       = 2'd0;
                    byte_ready_d = 1'b1;
`ifdef CHECKSUM_EN
                    xor_d        = 8'd0;
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end

            default: begin
                state_d      = S_FILL;
                word_idx_d   = '0;
                lane_d       = 2'd0;
                byte_ready_d = 1'b1;
            end
        endcase
    end

    assign byte_ready   = byte_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign done_writing = done_q;
    assign busy         = busy_q;
`ifdef CHECKSUM_EN
    assign checksum_err = cksum_err_q;
`else
    assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_packet_mem_writer.sv
// tb_packet_mem_writer: directed bench for packet_mem_writer with DEPTH_WORDS=4.
module tb_packet_mem_writer;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        out_of_data = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        done_writing;
    logic        busy;
    logic        checksum_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          done_total = 0;
    int          err_total = 0;

    packet_mem_writer #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .out_of_data  (out_of_data),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .done_writing (done_writing),
        .busy         (busy),
        .checksum_err (checksum_err)
    );

    always #5 clock = ~clock;

    // Record BRAM writes and pulses mid-cycle.
    always @(negedge clock) begin
        if (mem_we) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
        end
        if (done_writing) done_total++;
        if (checksum_err) err_total++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        byte_valid  = 1'b0;
        out_of_data = 1'b1;
        reset       = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    // Offer one byte; returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        forever begin
            rdy = byte_ready;
            @(posedge clock);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_byte_timeout: byte %0h not accepted within 200 cycles", b);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        do_reset();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hAA); send_byte(8'hBB);
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %0b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %0h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %0h expected 0", mem_wdata); end
        checks++; if (done_writing !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done_writing); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        checks++; if (checksum_err !== 1'b0) begin errors++; $display("FAIL rst_cksum_err: got %0b expected 0", checksum_err); end
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL rst_byte_ready: got %0b expected 1", byte_ready); end
        @(posedge clock);
        #1 reset = 1'b0;
        idle(1);
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b expected 1", byte_ready); end
        base = wr_addr_log.size();
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_first_we: got %0b expected 1", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_addr: got %0h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'hD4C3B2A1) begin errors++; $display("FAIL rst_first_wdata: got %0h expected d4c3b2a1", mem_wdata); end
        idle(1);
        checks++; if (wr_addr_log.size() - base !== 1) begin errors++; $display("FAIL rst_write_count: got %0d expected 1", wr_addr_log.size() - base); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL b2b_we0: got %0b expected 1", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL b2b_addr0: got %0h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h44332211) begin errors++; $display("FAIL b2b_wdata0: got %0h expected 44332211", mem_wdata); end
        send_byte(8'h55);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b_we_single: got %0b expected 0", mem_we); end
        send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL b2b_addr1: got %0h expected 4", mem_addr); end
        checks++; if (mem_wdata !== 32'h88776655) begin errors++; $display("FAIL b2b_wdata1: got %0h expected 88776655", mem_wdata); end
    endtask

    task automatic test_full_block();
        logic [31:0] exp_addr [4];
        logic [31:0] exp_data [4];
        int base;
        int bd;
        int nwr;
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_data = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
        do_reset();
        base = wr_addr_log.size();
        bd   = done_total;
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 2));
            send_byte(8'(8'h10 + i));
        end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL blk_last_we: got %0b expected 1", mem_we); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL blk_last_ready: got %0b expected 0", byte_ready); end
        idle(4);
        nwr = wr_addr_log.size() - base;
        checks++;
        if (nwr !== 4) begin
            errors++; $display("FAIL blk_write_count: got %0d expected 4", nwr);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (wr_addr_log[base+k] !== exp_addr[k]) begin errors++; $display("FAIL blk_addr%0d: got %0h expected %0h", k, wr_addr_log[base+k], exp_addr[k]); end
                checks++; if (wr_data_log[base+k] !== exp_data[k]) begin errors++; $display("FAIL blk_data%0d: got %0h expected %0h", k, wr_data_log[base+k], exp_data[k]); end
            end
        end
        checks++; if (done_total - bd !== 1) begin errors++; $display("FAIL blk_done_pulses: got %0d expected 1", done_total - bd); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL blk_ready: got %0b expected 0", byte_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL blk_busy: got %0b expected 1", busy); end
    endtask

    task automatic test_handoff();
        int base;
        int bd;
        base = wr_addr_log.size();
        bd   = done_total;
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        idle(3);
        out_of_data = 1'b0;
        idle(10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ho_busy_taken: got %0b expected 1", busy); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL ho_ready_taken: got %0b expected 0", byte_ready); end
        byte_valid  = 1'b0;
        out_of_data = 1'b1;
        idle(2);
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL ho_ready_drained: got %0b expected 1", byte_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ho_busy_drained: got %0b expected 0", busy); end
        checks++; if (wr_addr_log.size() - base !== 0) begin errors++; $display("FAIL ho_no_writes: got %0d expected 0", wr_addr_log.size() - base); end
        checks++; if (done_total - bd !== 0) begin errors++; $display("FAIL ho_no_done: got %0d expected 0", done_total - bd); end
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL ho_refill_we: got %0b expected 1", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL ho_refill_addr: got %0h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h88776655) begin errors++; $display("FAIL ho_refill_wdata: got %0h expected 88776655", mem_wdata); end
    endtask

    task automatic test_no_drain();
        int base;
        int bd;
        do_reset();
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        idle(4);
        base = wr_addr_log.size();
        bd   = done_total;
        byte_valid = 1'b1;
        byte_data  = 8'h99;
        idle(50);
        byte_valid = 1'b0;
        checks++; if (wr_addr_log.size() - base !== 0) begin errors++; $display("FAIL nd_no_writes: got %0d expected 0", wr_addr_log.size() - base); end
        checks++; if (done_total - bd !== 0) begin errors++; $display("FAIL nd_no_done: got %0d expected 0", done_total - bd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nd_busy: got %0b expected 1", busy); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL nd_ready: got %0b expected 0", byte_ready); end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] blk [16];
        int base;
        int bd;
        int be;
        // XOR of the block is 8'hFF ^ 8'h03 = 8'hFC
        blk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset();
        bd = done_total;
        be = err_total;
        for (int i = 0; i < 16; i++) send_byte(blk[i]);
        send_byte(8'hFD);
        idle(3);
        checks++; if (err_total - be !== 1) begin errors++; $display("FAIL ck_err_pulse: got %0d expected 1", err_total - be); end
        checks++; if (done_total - bd !== 0) begin errors++; $display("FAIL ck_bad_no_done: got %0d expected 0", done_total - bd); end
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL ck_bad_ready: got %0b expected 1", byte_ready); end
        base = wr_addr_log.size();
        bd   = done_total;
        be   = err_total;
        for (int i = 0; i < 16; i++) send_byte(blk[i]);
        send_byte(8'hFC);
        idle(3);
        checks++;
        if (wr_addr_log.size() - base !== 4) begin
            errors++; $display("FAIL ck_rewrite_count: got %0d expected 4", wr_addr_log.size() - base);
        end else begin
            checks++; if (wr_addr_log[base] !== 32'h0) begin errors++; $display("FAIL ck_rewrite_addr: got %0h expected 0", wr_addr_log[base]); end
        end
        checks++; if (done_total - bd !== 1) begin errors++; $display("FAIL ck_good_done: got %0d expected 1", done_total - bd); end
        checks++; if (err_total - be !== 0) begin errors++; $display("FAIL ck_good_no_err: got %0d expected 0", err_total - be); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ck_good_busy: got %0b expected 1", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_full_block();
        test_handoff();
        test_no_drain();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
